// File: rtl/alu_mp_pkg.sv
// Shared types and PSW constants for the XM23 multi-precision add/subtract sequencer.
package alu_mp_pkg;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;

   localparam int PSW_C = 0;
   localparam int PSW_Z = 1;
   localparam int PSW_N = 2;
   localparam int PSW_V = 4;
   localparam logic [15:0] PSW_ARITH_MSK = 16'h0017;

   function automatic logic [15:0] psw_pack(input logic c, input logic z, input logic n, input logic v);
      logic [15:0] p;
      p        = 16'h0000;
      p[PSW_C] = c;
      p[PSW_Z] = z;
      p[PSW_N] = n;
      p[PSW_V] = v;
      return p;
   endfunction

endpackage

// File: rtl/alu_addsub_core.sv
// Single-word add/subtract-with-carry core; SUB adds the inverted B word.
module alu_addsub_core #(
   parameter int WORD_W = 16
) (
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   input  logic              sub,
   input  logic              cin,
   output logic [WORD_W-1:0] result,
   output logic              cout,
   output logic              v
);

   logic [WORD_W-1:0] b_eff_s;
   logic [WORD_W:0]   sum_s;

   // Word-wide sum with carry-in
   always_comb begin
      b_eff_s = sub ? ~b : b;
      sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WORD_W{1'b0}}, cin};
   end

   assign result = sum_s[WORD_W-1:0];
   assign cout   = sum_s[WORD_W];
   assign v      = (a[WORD_W-1] == b_eff_s[WORD_W-1]) && (sum_s[WORD_W-1] != a[WORD_W-1]);

endmodule

// File: rtl/alu_mp_sequencer.sv
// Multi-precision ADD/SUB sequencer: streams operand words LSW first through one core.
// Define ALU_MP_ABORT_EN to add an abort input that cancels an operation in flight.
module alu_mp_sequencer
   import alu_mp_pkg::*;
#(
   parameter int MAX_WORDS = 4,
   parameter int WORD_W    = 16
) (
   input  logic                           clk,
   input  logic                           rst,
`ifdef ALU_MP_ABORT_EN
   input  logic                           abort,
`endif
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_op,
   input  logic                           req_use_c,
   input  logic                           req_c,
   input  logic [$clog2(MAX_WORDS+1)-1:0] req_words,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WORD_W-1:0]              in_a,
   input  logic [WORD_W-1:0]              in_b,
   output logic                           res_valid,
   input  logic                           res_ready,
   output logic [WORD_W-1:0]              res_data,
   output logic                           res_last,
   output logic [15:0]                    psw_out,
   output logic [15:0]                    psw_msk
);

   localparam int CNT_W = $clog2(MAX_WORDS + 1);

   state_e             state_q, state_d;
   op_e                op_q, op_d;
   logic [CNT_W-1:0]   words_q, words_d, cnt_q, cnt_d, words_eff_s;
   logic               carry_q, carry_d, nz_q, nz_d;
   logic               res_valid_q, res_valid_d, res_last_q, res_last_d;
   logic [WORD_W-1:0]  res_data_q, res_data_d, core_res_s;
   logic [15:0]        psw_q, psw_d, msk_q, msk_d;
   logic               core_cout_s, core_v_s, in_ready_s, in_hs_s, last_s, abort_s;

`ifdef ALU_MP_ABORT_EN
   assign abort_s = abort;
`else
   assign abort_s = 1'b0;
`endif

   alu_addsub_core #(.WORD_W(WORD_W)) u_core (
      .a      (in_a),
      .b      (in_b),
      .sub    (op_q == OP_SUB),
      .cin    (carry_q),
      .result (core_res_s),
      .cout   (core_cout_s),
      .v      (core_v_s)
   );

   // A stalled result consumer must back-pressure operand intake in the same cycle
   assign in_ready_s = (state_q == RUN) && (!res_valid_q || res_ready);
   assign in_hs_s    = in_valid && in_ready_s;
   assign last_s     = ((cnt_q + CNT_W'(1)) == words_q);

   // Clamp requested word count into 1..MAX_WORDS
   always_comb begin
      if (req_words == '0) begin
         words_eff_s = CNT_W'(1);
      end else if (int'(req_words) > MAX_WORDS) begin
         words_eff_s = CNT_W'(MAX_WORDS);
      end else begin
         words_eff_s = req_words;
      end
   end

   // Next-state and result-stage logic
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      words_d     = words_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      nz_d        = nz_q;
      res_valid_d = res_valid_q;
      res_last_d  = res_last_q;
      res_data_d  = res_data_q;
      psw_d       = psw_q;
      msk_d       = msk_q;
      if (abort_s && (state_q != IDLE)) begin
         state_d     = IDLE;
         res_valid_d = 1'b0;
         res_last_d  = 1'b0;
         psw_d       = 16'h0000;
         msk_d       = 16'h0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  op_d    = op_e'(req_op);
                  words_d = words_eff_s;
                  cnt_d   = '0;
                  carry_d = req_use_c ? req_c : req_op;
                  nz_d    = 1'b0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
            RUN: begin
               if (in_hs_s) begin
                  res_valid_d = 1'b1;
                  res_data_d  = core_res_s;
                  carry_d     = core_cout_s;
                  nz_d        = nz_q || (core_res_s != '0);
                  cnt_d       = cnt_q + CNT_W'(1);
                  if (last_s) begin
                     res_last_d = 1'b1;
                     psw_d      = psw_pack(core_cout_s, !(nz_q || (core_res_s != '0)),
                                           core_res_s[WORD_W-1], core_v_s);
                     msk_d      = PSW_ARITH_MSK;
                     state_d    = DRAIN;
                  end else begin
                     res_last_d = 1'b0;
                     psw_d      = 16'h0000;
                     msk_d      = 16'h0000;
                  end
               end else if (res_ready) begin
                  res_valid_d = 1'b0;
               end else begin
                  res_valid_d = res_valid_q;
               end
            end
            DRAIN: begin
               if (res_ready) begin
                  res_valid_d = 1'b0;
                  res_last_d  = 1'b0;
                  psw_d       = 16'h0000;
                  msk_d       = 16'h0000;
                  state_d     = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
            default: begin
               state_d     = IDLE;
               res_valid_d = 1'b0;
               res_last_d  = 1'b0;
            end
         endcase
      end
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_ADD;
         words_q     <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         nz_q        <= 1'b0;
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         res_data_q  <= '0;
         psw_q       <= 16'h0000;
         msk_q       <= 16'h0000;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         words_q     <= words_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         nz_q        <= nz_d;
         res_valid_q <= res_valid_d;
         res_last_q  <= res_last_d;
         res_data_q  <= res_data_d;
         psw_q       <= psw_d;
         msk_q       <= msk_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign in_ready  = in_ready_s;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_last  = res_last_q;
   assign psw_out   = psw_q;
   assign psw_msk   = msk_q;

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// Randomized bench for alu_mp_sequencer against a whole-number arithmetic reference model.
module tb_alu_mp_sequencer;

   localparam int MAXW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_op = 1'b0, req_use_c = 1'b0, req_c = 1'b0;
   logic [2:0]  req_words = 3'd0;
   logic        in_valid = 1'b0, res_ready = 1'b0;
   logic [15:0] in_a = 16'h0000, in_b = 16'h0000;
   logic        req_ready, in_ready, res_valid, res_last;
   logic [15:0] res_data, psw_out, psw_msk;
`ifdef ALU_MP_ABORT_EN
   logic        abort = 1'b0;
`endif
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_mp_sequencer #(.MAX_WORDS(MAXW), .WORD_W(16)) dut (
      .clk(clk), .rst(rst),
`ifdef ALU_MP_ABORT_EN
      .abort(abort),
`endif
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_use_c(req_use_c),
      .req_c(req_c), .req_words(req_words), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_last(res_last), .psw_out(psw_out), .psw_msk(psw_msk)
   );

   task automatic check_idle_outputs(input string tag);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL %s req_ready: got %b want 1", tag, req_ready); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready: got %b want 0", tag, in_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL %s res_valid: got %b want 0", tag, res_valid); end
      checks++; if (res_last !== 1'b0) begin errors++; $display("FAIL %s res_last: got %b want 0", tag, res_last); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL reset res_data: got %h want 0000", res_data); end
      checks++; if (psw_out !== 16'h0000) begin errors++; $display("FAIL reset psw_out: got %h want 0000", psw_out); end
      checks++; if (psw_msk !== 16'h0000) begin errors++; $display("FAIL reset psw_msk: got %h want 0000", psw_msk); end
      rst = 1'b0;
   endtask

   // mode 0: always ready/valid, 1: random handshakes, 2: consumer stall on cycles 2..4
   task automatic run_op(input logic op, input logic use_c, input logic c, input int rw,
                         input logic [63:0] a, input logic [63:0] b, input int mode);
      int n, accepted, received, cyc;
      logic [79:0] am, bm, r, mask;
      logic cin, ec, ez, en, ev, exp_rv, exp_ir, is_last;
      logic [15:0] exp_w [4];
      logic [15:0] exp_psw;
      n    = (rw == 0) ? 1 : ((rw > MAXW) ? MAXW : rw);
      mask = (80'd1 << (16 * n)) - 80'd1;
      am   = {16'h0000, a} & mask;
      bm   = {16'h0000, b} & mask;
      cin  = use_c ? c : op;
      if (!op) begin
         r  = am + bm + {79'd0, cin};
         ec = r[16 * n];
         r  = r & mask;
      end else if (am >= bm + {79'd0, !cin}) begin
         r  = am - bm - {79'd0, !cin};
         ec = 1'b1;
      end else begin
         r  = am + (80'd1 << (16 * n)) - bm - {79'd0, !cin};
         ec = 1'b0;
      end
      en = r[16 * n - 1];
      ez = (r == 80'd0);
      ev = op ? ((am[16*n-1] != bm[16*n-1]) && (en != am[16*n-1]))
              : ((am[16*n-1] == bm[16*n-1]) && (en != am[16*n-1]));
      exp_psw = {11'd0, ev, 1'b0, en, ez, ec};
      for (int k = 0; k < 4; k++) exp_w[k] = r[16*k +: 16];

      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_use_c = use_c; req_c = c; req_words = 3'(rw);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL req_accept req_ready: got %b want 1", req_ready); end
      @(negedge clk);
      req_valid = 1'b0;
      accepted = 0; received = 0; cyc = 0; exp_rv = 1'b0;
      while (received < n && cyc < 200) begin
         in_valid  = (mode == 1) ? 1'($urandom_range(0, 1)) : (accepted < n);
         in_a      = (accepted < n) ? a[16*accepted +: 16] : 16'($urandom);
         in_b      = (accepted < n) ? b[16*accepted +: 16] : 16'($urandom);
         res_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : ((mode == 2) ? !(cyc >= 2 && cyc < 5) : 1'b1);
         req_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         #1;
         exp_ir = (accepted < n) && (!exp_rv || res_ready);
         checks++; if (in_ready !== exp_ir) begin errors++; $display("FAIL in_ready cyc%0d: got %b want %b", cyc, in_ready, exp_ir); end
         checks++; if (res_valid !== exp_rv) begin errors++; $display("FAIL res_valid cyc%0d: got %b want %b", cyc, res_valid, exp_rv); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy req_ready cyc%0d: got %b want 0", cyc, req_ready); end
         if (exp_rv) begin
            is_last = (received == n - 1);
            checks++; if (res_data !== exp_w[received]) begin errors++; $display("FAIL res_data word%0d: got %h want %h", received, res_data, exp_w[received]); end
            checks++; if (res_last !== is_last) begin errors++; $display("FAIL res_last word%0d: got %b want %b", received, res_last, is_last); end
            if (is_last) begin
               checks++; if (psw_out !== exp_psw) begin errors++; $display("FAIL psw_out: got %h want %h", psw_out, exp_psw); end
               checks++; if (psw_msk !== 16'h0017) begin errors++; $display("FAIL psw_msk: got %h want 0017", psw_msk); end
            end
            if (res_ready) received++;
         end
         if (in_valid && exp_ir) begin
            accepted++;
            exp_rv = 1'b1;
         end else if (res_ready) begin
            exp_rv = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      checks++; if (received != n) begin errors++; $display("FAIL op_timeout: got %0d words want %0d", received, n); end
      in_valid = 1'b0; res_ready = 1'b0; req_valid = 1'b0;
      #1;
      check_idle_outputs("post_op");
   endtask

   task automatic test_directed();
      run_op(1'b1, 1'b0, 1'b0, 2, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 0);
      run_op(1'b0, 1'b0, 1'b0, 2, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 0);
      run_op(1'b1, 1'b1, 1'b0, 1, 64'h0000_0000_0000_8000, 64'h0000_0000_0000_0001, 0);
   endtask

   task automatic test_stall();
      run_op(1'b1, 1'b0, 1'b0, 3, 64'h0000_1234_1234_1234, 64'h0000_1234_1234_1234, 2);
   endtask

   task automatic test_word_count();
      run_op(1'b0, 1'b0, 1'b0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
      run_op(1'b1, 1'b0, 1'b0, 7, {$urandom, $urandom}, {$urandom, $urandom}, 1);
   endtask

   task automatic test_random();
      logic [63:0] a, b;
      for (int i = 0; i < 12; i++) begin
         a = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = ~a;
            2:       b = 64'h0000_0000_0000_0001;
            default: b = {$urandom, $urandom};
         endcase
         run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), a, b, 1);
      end
   endtask

   task automatic start_four_words();
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b0; req_use_c = 1'b0; req_words = 3'd4;
      @(negedge clk);
      req_valid = 1'b0; res_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_a = 16'($urandom); in_b = 16'($urandom);
         @(negedge clk);
      end
      in_a = 16'($urandom); in_b = 16'($urandom);
   endtask

   task automatic test_reset_mid_op();
      start_four_words();
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("async_reset");
      checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL async_reset res_data: got %h want 0000", res_data); end
      checks++; if (psw_out !== 16'h0000) begin errors++; $display("FAIL async_reset psw_out: got %h want 0000", psw_out); end
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
      run_op(1'b0, 1'b0, 1'b0, 4, {$urandom, $urandom}, {$urandom, $urandom}, 0);
   endtask

`ifdef ALU_MP_ABORT_EN
   task automatic test_abort();
      start_four_words();
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
      #1;
      check_idle_outputs("abort");
      run_op(1'b1, 1'b0, 1'b0, 4, {$urandom, $urandom}, {$urandom, $urandom}, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_word_count();
      test_random();
      test_reset_mid_op();
`ifdef ALU_MP_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mp_sequencer.md
Name: alu_mp_sequencer

Overview:
- Multi-precision add/subtract sequencer for the XM23 execute stage.
- Drives a single 16-bit add/subtract-with-carry core word by word, least-significant word first, over 1..MAX_WORDS operand words, chaining carry/borrow between words.
- Operand words stream in and result words stream out over valid/ready handshakes.
- On the final word it emits XM23 PSW flags plus a PSW update mask.

Parameters:
- MAX_WORDS, 4, maximum words per operation (must be ≥ 1).
- WORD_W, 16, word width; the PSW is fixed at 16 bits.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, operation request.
- req_ready, out, 1, sequencer idle, request can be accepted.
- req_op, in, 1, 0 = ADD, 1 = SUB.
- req_use_c, in, 1, 1 = seed first-word carry from req_c (ADDC/SUBC); 0 = natural seed.
- req_c, in, 1, incoming PSW C bit.
- req_words, in, $clog2(MAX_WORDS+1), word count.
- in_valid, in, 1, operand word pair present.
- in_ready, out, 1, sequencer accepts operand pair.
- in_a, in, WORD_W, operand A word.
- in_b, in, WORD_W, operand B word.
- res_valid, out, 1, result word present.
- res_ready, in, 1, consumer accepts result.
- res_data, out, WORD_W, result word.
- res_last, out, 1, result word is the most-significant word.
- psw_out, out, 16, flags; valid only when res_valid && res_last.
- psw_msk, out, 16, PSW bits to update; valid only when res_valid && res_last.

Behaviour:
- Clock/reset interface: single clock clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE, req_ready=1, in_ready=0, res_valid=0, res_last=0, res_data=0, psw_out=0, psw_msk=0; internal carry, word counter and Z accumulator all 0.
- FSM IDLE → RUN → DRAIN → IDLE:
  - IDLE: req_ready=1. A cycle with req_valid=1 captures op, words and seed carry, then moves to RUN.
  - RUN: in_ready = !res_valid || res_ready. Each in handshake computes one word into the registered result stage (latency 1 cycle) and increments the counter. When the last word is accepted, move to DRAIN.
  - DRAIN: in_ready=0. Hold res_valid until res_ready=1, then move to IDLE. IDLE is usable on the next cycle.
- Throughput: 1 word per cycle with no stalls. A stalled res_ready back-pressures in_ready in the same cycle.
- Arithmetic:
  - r = a + b' + cin over WORD_W+1 bits.
  - b' = b for ADD, ~b for SUB.
  - Word 0 cin = req_use_c ? req_c : req_op. Later words use the previous word's carry-out.
  - C follows XM23 convention: for SUB, C=1 means no borrow.
- Word-count rules: req_words=0 is treated as 1; req_words > MAX_WORDS is clamped to MAX_WORDS.
- Flags, presented with the last word:
  - C = final carry-out (bit 0).
  - Z = every result word was zero (bit 1).
  - N = MSW[15] (bit 2).
  - V = (a15 == b'15) && (r15 != a15) on the MSW (bit 4).
  - psw_msk = 16'h0017. All other psw_out bits are 0.
- Result hold: res_data, res_last and flags are held stable while res_valid && !res_ready.
- Requests outside IDLE are ignored (req_ready=0). in_valid outside RUN is ignored.
- Reset mid-operation aborts immediately: the partial result is discarded and no res_last is issued.

Optional Feature:
- Macro: ALU_MP_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in RUN or DRAIN forces IDLE on the next edge, clears res_valid, and issues no res_last. abort in IDLE has no effect.
- Undefined: the port is absent and operations always complete.

Decomposition:
- Package alu_mp_pkg holds:
  - enum state_e {IDLE, RUN, DRAIN};
  - enum op_e {OP_ADD, OP_SUB};
  - PSW bit-index constants PSW_C=0, PSW_Z=1, PSW_N=2, PSW_V=4;
  - PSW_ARITH_MSK=16'h0017.
- One combinational sub-module, alu_addsub_core: inputs a, b, sub, cin; outputs result, cout, v. The sequencer instantiates it once.

Test Plan:
- SUB, 2 words, req_use_c=0: A=0x0001_0000, B=0x0000_0001 → words 0xFFFF then 0x0000; C=1, Z=0, N=0, V=0; psw_msk=0x0017.
- ADD, 2 words: A=0x0000_FFFF, B=0x0000_0001 → 0x0000, 0x0001; C=0, Z=0. Carry chains into the MSW.
- SUBC, 1 word, req_use_c=1, req_c=0: 0x8000 − 0x0001 − 1 → 0x7FFE; V=1, N=0, C=1.
- SUB, 3 words, equal operands 0x1234 per word → all words 0x0000; Z=1, C=1. Hold res_ready=0 for 3 cycles mid-stream: in_ready drops and res_data stays stable.
- req_words=0 and req_words=7 (MAX_WORDS=4) → exactly 1 and 4 words processed respectively; req_ready=0 throughout.
- Assert rst during word 2 of 4 → all outputs return to reset values asynchronously; the next request completes correctly. With ALU_MP_ABORT_EN defined, repeat using abort instead of rst.
